// File: rtl/data_bus_matrix_n.sv
// One-master, NUM_SLAVES-slave load/store bus matrix with base/mask decode,
// decode-error and timeout responses, and a one-deep pending read behind a write.
module data_bus_matrix_n #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int STRB_W = DATA_W / 8,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK = '0,
  parameter int TIMEOUT = 255
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic                         M_RdReq,
  input  logic [ADDR_W-1:0]            M_RdAddr,
  input  logic                         M_WrReq,
  input  logic [ADDR_W-1:0]            M_WrAddr,
  input  logic [DATA_W-1:0]            M_WrData,
  input  logic [STRB_W-1:0]            M_WrStrb,
  output logic [DATA_W-1:0]            M_RdData,
  output logic                         M_RdDone,
  output logic                         M_WrDone,
  output logic                         M_Err,
  output logic                         Busy,
  output logic [NUM_SLAVES-1:0]        S_RdReq,
  output logic [ADDR_W-1:0]            S_RdAddr,
  input  logic [NUM_SLAVES*DATA_W-1:0] S_RdData,
  input  logic [NUM_SLAVES-1:0]        S_RdReady,
  output logic [NUM_SLAVES-1:0]        S_WrReq,
  output logic [ADDR_W-1:0]            S_WrAddr,
  output logic [DATA_W-1:0]            S_WrData,
  output logic [STRB_W-1:0]            S_WrStrb,
  input  logic [NUM_SLAVES-1:0]        S_WrReady
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_WAIT = 2'd1;
  localparam logic [1:0] WR_WAIT = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  logic [1:0]            state_reg;
  logic [SEL_W-1:0]      sel_reg;
  logic                  is_rd_reg;
  logic                  derr_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [ADDR_W-1:0]     rd_addr_reg;
  logic [ADDR_W-1:0]     wr_addr_reg;
  logic [DATA_W-1:0]     wr_data_reg;
  logic [STRB_W-1:0]     wr_strb_reg;
  logic                  pend_reg;
  logic [ADDR_W-1:0]     pend_addr_reg;
  logic [NUM_SLAVES-1:0] s_rd_req_reg;
  logic [NUM_SLAVES-1:0] s_wr_req_reg;
  logic                  rd_done_reg;
  logic                  wr_done_reg;
  logic                  err_reg;
  logic [DATA_W-1:0]     rd_data_reg;

  logic [NUM_SLAVES-1:0] rd_hit;
  logic [NUM_SLAVES-1:0] wr_hit;
  logic [NUM_SLAVES-1:0] pend_hit;
  logic                  sel_ready;
  logic [DATA_W-1:0]     sel_rd_data;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_decode
      assign rd_hit[gi]   = (M_RdAddr & SLV_MASK[gi*ADDR_W +: ADDR_W]) == SLV_BASE[gi*ADDR_W +: ADDR_W];
      assign wr_hit[gi]   = (M_WrAddr & SLV_MASK[gi*ADDR_W +: ADDR_W]) == SLV_BASE[gi*ADDR_W +: ADDR_W];
      assign pend_hit[gi] = (pend_addr_reg & SLV_MASK[gi*ADDR_W +: ADDR_W]) == SLV_BASE[gi*ADDR_W +: ADDR_W];
    end
  endgenerate

  // Lowest-index hit wins when map entries overlap.
  function automatic logic [SEL_W-1:0] first_hit(input logic [NUM_SLAVES-1:0] hit);
    first_hit = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (hit[i]) first_hit = SEL_W'(i);
    end
  endfunction

  function automatic logic [NUM_SLAVES-1:0] onehot(input logic [SEL_W-1:0] s);
    onehot = '0;
    onehot[s] = 1'b1;
  endfunction

  assign sel_ready   = is_rd_reg ? S_RdReady[sel_reg] : S_WrReady[sel_reg];
  assign sel_rd_data = S_RdData[int'(sel_reg)*DATA_W +: DATA_W];

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_reg     <= IDLE;
      sel_reg       <= '0;
      is_rd_reg     <= 1'b0;
      derr_reg      <= 1'b0;
      cnt_reg       <= '0;
      rd_addr_reg   <= '0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
      wr_strb_reg   <= '0;
      pend_reg      <= 1'b0;
      pend_addr_reg <= '0;
      s_rd_req_reg  <= '0;
      s_wr_req_reg  <= '0;
      rd_done_reg   <= 1'b0;
      wr_done_reg   <= 1'b0;
      err_reg       <= 1'b0;
      rd_data_reg   <= '0;
    end else begin
      rd_done_reg <= 1'b0;
      wr_done_reg <= 1'b0;
      err_reg     <= 1'b0;
      rd_data_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (M_WrReq) begin
            is_rd_reg   <= 1'b0;
            wr_addr_reg <= M_WrAddr;
            wr_data_reg <= M_WrData;
            wr_strb_reg <= M_WrStrb;
            if (M_RdReq) begin
              pend_reg      <= 1'b1;
              pend_addr_reg <= M_RdAddr;
            end
            if (|wr_hit) begin
              state_reg    <= WR_WAIT;
              sel_reg      <= first_hit(wr_hit);
              s_wr_req_reg <= onehot(first_hit(wr_hit));
              cnt_reg      <= '0;
            end else begin
              state_reg <= RESP;
              derr_reg  <= 1'b1;
            end
          end else if (M_RdReq) begin
            is_rd_reg   <= 1'b1;
            rd_addr_reg <= M_RdAddr;
            if (|rd_hit) begin
              state_reg    <= RD_WAIT;
              sel_reg      <= first_hit(rd_hit);
              s_rd_req_reg <= onehot(first_hit(rd_hit));
              cnt_reg      <= '0;
            end else begin
              state_reg <= RESP;
              derr_reg  <= 1'b1;
            end
          end
        end
        RD_WAIT, WR_WAIT: begin
          // Ready beats the timeout when both land in the same cycle.
          if (sel_ready || cnt_reg == CNT_W'(TIMEOUT)) begin
            state_reg    <= RESP;
            s_rd_req_reg <= '0;
            s_wr_req_reg <= '0;
            rd_done_reg  <= is_rd_reg;
            wr_done_reg  <= ~is_rd_reg;
            err_reg      <= ~sel_ready;
            if (is_rd_reg && sel_ready) rd_data_reg <= sel_rd_data;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          // A decode error spends one RESP cycle before its Done so its
          // latency matches a zero-wait slave.
          if (derr_reg) begin
            derr_reg    <= 1'b0;
            rd_done_reg <= is_rd_reg;
            wr_done_reg <= ~is_rd_reg;
            err_reg     <= 1'b1;
          end else if (pend_reg) begin
            pend_reg    <= 1'b0;
            is_rd_reg   <= 1'b1;
            rd_addr_reg <= pend_addr_reg;
            if (|pend_hit) begin
              state_reg    <= RD_WAIT;
              sel_reg      <= first_hit(pend_hit);
              s_rd_req_reg <= onehot(first_hit(pend_hit));
              cnt_reg      <= '0;
            end else begin
              derr_reg <= 1'b1;
            end
          end else begin
            state_reg <= IDLE;
          end
        end
      endcase
    end
  end

  assign M_RdData = rd_data_reg;
  assign M_RdDone = rd_done_reg;
  assign M_WrDone = wr_done_reg;
  assign M_Err    = err_reg;
  assign Busy     = (state_reg != IDLE) | pend_reg;
  assign S_RdReq  = s_rd_req_reg;
  assign S_WrReq  = s_wr_req_reg;
  assign S_RdAddr = (state_reg == RD_WAIT) ? rd_addr_reg : '0;
  assign S_WrAddr = (state_reg == WR_WAIT) ? wr_addr_reg : '0;
  assign S_WrData = (state_reg == WR_WAIT) ? wr_data_reg : '0;
  assign S_WrStrb = (state_reg == WR_WAIT) ? wr_strb_reg : '0;

endmodule

// File: tb/tb_data_bus_matrix_n.sv
// Directed bench for data_bus_matrix_n: a table of single transactions plus
// hand-written sequences for read-behind-write, busy drop and async reset.
module tb_data_bus_matrix_n;

  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  logic          Clk = 1'b0;
  logic          Rst = 1'b0;
  logic          m_rd_req = 1'b0;
  logic [AW-1:0] m_rd_addr = '0;
  logic          m_wr_req = 1'b0;
  logic [AW-1:0] m_wr_addr = '0;
  logic [DW-1:0] m_wr_data = '0;
  logic [SW-1:0] m_wr_strb = '0;
  logic [DW-1:0] m_rd_data;
  logic          m_rd_done, m_wr_done, m_err, busy;
  logic [NS-1:0] s_rd_req, s_wr_req;
  logic [AW-1:0] s_rd_addr, s_wr_addr;
  logic [DW-1:0] s_wr_data;
  logic [SW-1:0] s_wr_strb;
  logic [NS*DW-1:0] s_rd_data = '0;
  logic [NS-1:0] s_rd_ready = '0;
  logic [NS-1:0] s_wr_ready = '0;

  int passed = 0;
  int total  = 0;

  data_bus_matrix_n #(
    .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW), .STRB_W(SW),
    .SLV_BASE({32'h8000_0000, 32'hA000_0000, 32'h9000_0000, 32'h8000_0000}),
    .SLV_MASK({32'hC000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000}),
    .TIMEOUT(8)
  ) dut (
    .Clk(Clk), .Rst(Rst),
    .M_RdReq(m_rd_req), .M_RdAddr(m_rd_addr),
    .M_WrReq(m_wr_req), .M_WrAddr(m_wr_addr), .M_WrData(m_wr_data), .M_WrStrb(m_wr_strb),
    .M_RdData(m_rd_data), .M_RdDone(m_rd_done), .M_WrDone(m_wr_done), .M_Err(m_err),
    .Busy(busy),
    .S_RdReq(s_rd_req), .S_RdAddr(s_rd_addr), .S_RdData(s_rd_data), .S_RdReady(s_rd_ready),
    .S_WrReq(s_wr_req), .S_WrAddr(s_wr_addr), .S_WrData(s_wr_data), .S_WrStrb(s_wr_strb),
    .S_WrReady(s_wr_ready)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else passed++;
  endtask

  typedef struct {
    logic          is_wr;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [3:0]    strb;
    int            ready_cyc;   // cycle the selected slave raises ready, 0 = never
    logic [31:0]   sdata;
    int            sel;         // -1 = unmapped
    int            exp_req;
    int            exp_done;
    logic          exp_err;
    logic [31:0]   exp_rdata;
  } vec_t;

  vec_t vecs[9];

  task automatic run_vec(input int idx, input vec_t v);
    logic [NS-1:0] exp_vec;
    logic [NS-1:0] req_now, other_req;
    logic          done_now, other_done;
    int req_cnt = 0, bad = 0, done_cycle = -1;
    logic err_seen = 1'b0;
    logic [31:0] rdata_seen = '0;
    exp_vec = (v.sel >= 0) ? NS'(1) << v.sel : '0;
    for (int i = 0; i < NS; i++)
      s_rd_data[i*DW +: DW] = (i == v.sel) ? v.sdata : 32'hBAD0_0000 + 32'(i);
    s_rd_ready = '1;
    s_wr_ready = '1;
    if (v.sel >= 0) begin
      if (v.is_wr) s_wr_ready = ~exp_vec;
      else         s_rd_ready = ~exp_vec;
    end
    @(posedge Clk); #1;
    m_rd_req  = ~v.is_wr;
    m_wr_req  = v.is_wr;
    m_rd_addr = v.addr;
    m_wr_addr = v.addr;
    m_wr_data = v.wdata;
    m_wr_strb = v.strb;
    for (int c = 1; c <= 30 && done_cycle < 0; c++) begin
      @(posedge Clk); #1;
      m_rd_req = 1'b0;
      m_wr_req = 1'b0;
      if (v.sel >= 0) begin
        if (v.is_wr) s_wr_ready = (v.ready_cyc == c) ? '1 : ~exp_vec;
        else         s_rd_ready = (v.ready_cyc == c) ? '1 : ~exp_vec;
      end
      @(negedge Clk);
      req_now    = v.is_wr ? s_wr_req : s_rd_req;
      other_req  = v.is_wr ? s_rd_req : s_wr_req;
      done_now   = v.is_wr ? m_wr_done : m_rd_done;
      other_done = v.is_wr ? m_rd_done : m_wr_done;
      if (req_now != '0) begin
        if (req_now !== exp_vec) bad++;
        else req_cnt++;
        if (v.is_wr && (s_wr_addr !== v.addr || s_wr_data !== v.wdata || s_wr_strb !== v.strb)) bad++;
        if (!v.is_wr && s_rd_addr !== v.addr) bad++;
      end
      if (other_req !== '0 || other_done || !busy) bad++;
      if (!done_now && m_err) bad++;
      if (done_now) begin
        done_cycle = c;
        err_seen   = m_err;
        rdata_seen = m_rd_data;
      end
    end
    @(posedge Clk); #1;
    s_rd_ready = '0;
    s_wr_ready = '0;
    @(negedge Clk);
    check($sformatf("v%0d_done_cycle", idx), 64'(done_cycle), 64'(v.exp_done));
    check($sformatf("v%0d_err", idx), 64'(err_seen), 64'(v.exp_err));
    check($sformatf("v%0d_req_cycles", idx), 64'(req_cnt), 64'(v.exp_req));
    check($sformatf("v%0d_protocol", idx), 64'(bad), 64'd0);
    check($sformatf("v%0d_post_idle", idx), {60'd0, m_rd_done, m_wr_done, m_err, busy}, 64'd0);
    if (!v.is_wr) check($sformatf("v%0d_rdata", idx), 64'(rdata_seen), 64'(v.exp_rdata));
    $display("vec %0d: %s addr=%h done@%0d err=%0b rdata=%h req_cycles=%0d",
             idx, v.is_wr ? "WR" : "RD", v.addr, done_cycle, err_seen, rdata_seen, req_cnt);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_done_err_busy"}, {60'd0, m_rd_done, m_wr_done, m_err, busy}, 64'd0);
    check({tag, "_s_req"}, {56'd0, s_rd_req, s_wr_req}, 64'd0);
    check({tag, "_s_addr"}, {s_rd_addr, s_wr_addr}, 64'd0);
    check({tag, "_data"}, {m_rd_data, s_wr_data}, 64'd0);
    check({tag, "_strb"}, 64'(s_wr_strb), 64'd0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 32'h8000_0010, 32'h0,    4'h0, 1, 32'hDEAD_BEEF, 0, 1, 2, 1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 32'hA000_0040, 32'h1234, 4'hF, 6, 32'h0,         2, 6, 7, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 32'h0000_0004, 32'h0,    4'h0, 1, 32'h0,        -1, 0, 2, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 32'h9000_0000, 32'h0,    4'h0, 0, 32'h1357_2468, 1, 9, 10, 1'b1, 32'h0};
    vecs[4] = '{1'b0, 32'hB000_0008, 32'h0,    4'h0, 3, 32'hCAFE_F00D, 3, 3, 4, 1'b0, 32'hCAFE_F00D};
    vecs[5] = '{1'b1, 32'h4000_0000, 32'h55,   4'h3, 1, 32'h0,        -1, 0, 2, 1'b1, 32'h0};
    vecs[6] = '{1'b0, 32'h9000_0100, 32'h0,    4'h0, 9, 32'h5A5A_A5A5, 1, 9, 10, 1'b0, 32'h5A5A_A5A5};
    vecs[7] = '{1'b1, 32'h8000_0000, 32'hABCD, 4'hC, 0, 32'h0,         0, 9, 10, 1'b1, 32'h0};
    vecs[8] = '{1'b0, 32'h8800_0000, 32'h0,    4'h0, 8, 32'h0F0F_1234, 0, 8, 9, 1'b0, 32'h0F0F_1234};

    #1 Rst = 1'b1;
    #2 check_outputs_zero("reset");
    repeat (3) @(posedge Clk);
    #1 Rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Read and write together, zero-wait slaves, plus a pulse dropped while busy.
    begin
      int wr_done_at = -1, rd_done_at = -1, wr_cnt = 0, rd_cnt = 0, bad = 0;
      logic [31:0] rdata = '0;
      for (int i = 0; i < NS; i++) s_rd_data[i*DW +: DW] = 32'h1111_1111 * 32'(i + 1);
      s_rd_ready = '1;
      s_wr_ready = '1;
      @(posedge Clk); #1;
      m_wr_req = 1'b1; m_wr_addr = 32'h9000_0020; m_wr_data = 32'h77; m_wr_strb = 4'h1;
      m_rd_req = 1'b1; m_rd_addr = 32'h8000_0030;
      for (int c = 1; c <= 10; c++) begin
        @(posedge Clk); #1;
        m_wr_req = 1'b0;
        m_rd_req = (c == 2);
        if (c == 2) m_rd_addr = 32'hA000_0000;
        @(negedge Clk);
        if (m_wr_done) begin wr_cnt++; wr_done_at = c; end
        if (m_rd_done) begin rd_cnt++; rd_done_at = c; rdata = m_rd_data; end
        if (busy !== (c <= 4)) bad++;
        if (s_rd_req[2] || m_err) bad++;
        if (c == 1 && (s_wr_req !== 4'b0010 || s_wr_data !== 32'h77)) bad++;
        if (c == 3 && (s_rd_req !== 4'b0001 || s_rd_addr !== 32'h8000_0030)) bad++;
      end
      check("rw_wr_done_cycle", 64'(wr_done_at), 64'd2);
      check("rw_rd_done_cycle", 64'(rd_done_at), 64'd4);
      check("rw_done_counts", {wr_cnt[31:0], rd_cnt[31:0]}, {32'd1, 32'd1});
      check("rw_rdata", 64'(rdata), 64'h1111_1111);
      check("rw_protocol", 64'(bad), 64'd0);
      $display("seq rw: wr_done@%0d rd_done@%0d rdata=%h", wr_done_at, rd_done_at, rdata);
    end

    // Asynchronous reset in the middle of a read wait.
    begin
      int dones = 0;
      s_rd_ready = '0;
      s_wr_ready = '0;
      @(posedge Clk); #1;
      m_rd_req = 1'b1; m_rd_addr = 32'h8000_0000;
      @(posedge Clk); #1;
      m_rd_req = 1'b0;
      @(negedge Clk);
      check("rst_pre_req", {59'd0, s_rd_req, busy}, {59'd0, 4'b0001, 1'b1});
      @(posedge Clk); #2;
      Rst = 1'b1;
      #1 check_outputs_zero("rst_mid");
      repeat (2) @(posedge Clk);
      #1 Rst = 1'b0;
      for (int c = 0; c < 12; c++) begin
        @(negedge Clk);
        if (m_rd_done || m_wr_done || busy || s_rd_req != '0) dones++;
      end
      check("rst_no_done", 64'(dones), 64'd0);
      $display("seq reset: activity_after_release=%0d", dones);
    end
    run_vec(9, vecs[0]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/data_bus_matrix_n.md
Name: data_bus_matrix_n

Overview:
- Parametrised successor to the fixed three-slave data bus matrix.
- Connects the core's load/store port (one master) to NUM_SLAVES memory-mapped slaves, such as RAM, VGA and Timer0, through a programmable base/mask address map.
- Adds features the fixed matrix lacks: decode-error response, per-transaction timeout, and a one-deep pending queue for a read that arrives together with a write.

Parameters:
- NUM_SLAVES, 4: number of slave ports (1..8).
- ADDR_W, 64: address width.
- DATA_W, 64: data width.
- STRB_W, DATA_W/8: byte strobe width.
- SLV_BASE, 0: NUM_SLAVES*ADDR_W flattened base addresses; slave i occupies bits [i*ADDR_W +: ADDR_W].
- SLV_MASK, 0: NUM_SLAVES*ADDR_W flattened decode masks, same packing.
- TIMEOUT, 255: maximum number of wait cycles for slave ready (>=1).

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  reset, asynchronous, active-high.
- M_RdReq  in  1  single-cycle read request pulse.
- M_RdAddr  in  ADDR_W  read address.
- M_WrReq  in  1  single-cycle write request pulse.
- M_WrAddr  in  ADDR_W  write address.
- M_WrData  in  DATA_W  write data.
- M_WrStrb  in  STRB_W  write byte strobes.
- M_RdData  out  DATA_W  read data; valid only while M_RdDone=1.
- M_RdDone  out  1  one-cycle read completion pulse.
- M_WrDone  out  1  one-cycle write completion pulse.
- M_Err  out  1  error flag, qualified by Done: 1 = decode error or timeout.
- Busy  out  1  high while a transaction is in flight or a read is pending.
- S_RdReq  out  NUM_SLAVES  per-slave read request, held until ready.
- S_RdAddr  out  ADDR_W  shared read address to all slaves.
- S_RdData  in  NUM_SLAVES*DATA_W  per-slave read data, flattened.
- S_RdReady  in  NUM_SLAVES  per-slave read ready.
- S_WrReq  out  NUM_SLAVES  per-slave write request, held until ready.
- S_WrAddr  out  ADDR_W  shared write address.
- S_WrData  out  DATA_W  shared write data.
- S_WrStrb  out  STRB_W  shared write strobes.
- S_WrReady  in  NUM_SLAVES  per-slave write ready.

Behaviour:
- Reset, asynchronous, any state:
  - FSM returns to IDLE; the pending read and the timeout counter are cleared.
  - All outputs go to 0, including M_RdData, the S_* buses, Busy and M_Err.
  - An in-flight transaction is abandoned and produces no Done.
- Address decode:
  - Slave i is hit when (addr & MASK_i) == BASE_i.
  - If several slaves hit, the lowest index wins.
  - If no slave hits, the transaction is a decode error.
- Acceptance:
  - Requests are sampled only in IDLE with Busy=0.
  - Pulses arriving while Busy=1 are ignored and dropped silently.
  - On acceptance, address, data and strobes are registered and Busy rises on the next cycle.
- FSM states: IDLE, RD_WAIT, WR_WAIT, RESP.
  - IDLE -> WR_WAIT on M_WrReq; WrReq wins when it arrives together with RdReq.
  - IDLE -> RD_WAIT on M_RdReq alone.
  - IDLE -> RESP directly on a decode error. The slave is never touched and Done fires with Err=1 on the next cycle.
  - RD_WAIT / WR_WAIT -> RESP when the selected slave's ready is high.
  - RD_WAIT / WR_WAIT -> RESP on timeout.
  - RESP -> RD_WAIT (or RESP on a decode error) if a read is pending; otherwise RESP -> IDLE.
- Simultaneous read and write in IDLE:
  - The write is served first.
  - The read address is latched into the pending register and issued right after the write's RESP.
  - Order of responses: WrDone, then RdDone.
- Slave request:
  - S_xxReq[sel] is asserted, registered, in the first WAIT cycle and held until ready or timeout.
  - Other request bits stay 0. Ready from non-selected slaves is ignored.
  - The S_* address/data buses are driven from the registered values during WAIT. They are 0 in IDLE.
- Latency:
  - Acceptance at cycle 0; slave request from cycle 1.
  - Ready sampled at cycle k (k>=1) drops the request at k+1.
  - M_xxDone pulses at cycle k+1. For reads, M_RdData is registered from S_RdData[sel] at cycle k.
  - Zero-wait slave (ready at cycle 1): Done at cycle 2.
- Timeout:
  - The counter clears on entering WAIT and increments each cycle that ready is low.
  - At count == TIMEOUT the request drops and the FSM enters RESP with Err=1 (RdData=0).
  - A ready arriving in the same cycle as the timeout wins: normal completion, Err=0.
- Done/Err pulses last exactly one cycle. M_Err=0 whenever Done=0.
- Busy = (state != IDLE) | pending. Busy falls in the cycle after the final RESP.

Test Plan:
- Read, slave 0 (BASE 0x8000_0000, MASK 0xF000_0000), addr 0x8000_0010, ready on cycle 1, data 0xDEAD_BEEF -> S_RdReq=0b0001 on cycle 1 only; RdDone with RdData 0xDEAD_BEEF on cycle 2; Err=0.
- Write to slave 2 with ready delayed 5 cycles, data 0x1234, strb 0x0F -> S_WrReq[2] high cycles 1-6 with S_WrData 0x1234, S_WrStrb 0x0F; WrDone on cycle 7; no other S_WrReq bit toggles.
- Unmapped addr 0x0000_0004 read -> no S_RdReq asserted; RdDone=1, Err=1, RdData=0 on cycle 2.
- TIMEOUT=8, slave never ready -> S_RdReq high for 9 cycles; RdDone with Err=1 one cycle after timeout; next request proceeds normally.
- Same-cycle WrReq to slave 1 and RdReq to slave 0 (both zero-wait) -> WrDone on cycle 2, RdDone after the read's own WAIT; Busy stays high throughout; a third pulse issued while Busy is ignored.
- Rst asserted mid RD_WAIT -> all outputs 0 immediately (asynchronous); no Done after release; a fresh read completes normally.
